// File: rtl/dmem_pkg.sv
// Shared types, widths and the request error check for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'h0000_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  // Misaligned, beyond the array, or a write that enables no byte lane.
  function automatic logic req_err(input req_t r, input int unsigned depth_words);
    return ((r.addr & ADDR_ALIGN_MASK) != '0) ||
           (r.addr[31:2] >= 30'(depth_words)) ||
           (r.we && (r.be == '0));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word array with byte-lane synchronous write and a registered read port.
// Latency: read data valid the cycle after rd_en; no backpressure, caller owns sequencing.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [BE_W-1:0]                be,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately not reset; the read register is masked by the owner.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target with programmable wait states and error flagging.
// Latency: response WAIT_CYCLES+1 cycles after accept; req_ready low until the response handshakes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  req_t              req_q, req_d, in_req, acc_req;
  logic              err_q, err_d, acc_err;
  logic              rd_ok_q, rd_ok_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mem_en, mem_we, mem_re;
  logic [DATA_W-1:0] arr_rdata;

  assign in_req = {req_we, req_addr, req_wdata, req_be};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      err_q     <= 1'b0;
      rd_ok_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      err_q     <= err_d;
      rd_ok_q   <= rd_ok_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    err_d     = err_q;
    rd_ok_d   = rd_ok_q;
    rsp_err_d = rsp_err_q;
    mem_en    = 1'b0;
    // With zero wait states the access uses the live request, otherwise the captured one.
    acc_req   = (state_q == IDLE) ? in_req : req_q;
    acc_err   = (state_q == IDLE) ? req_err(acc_req, DEPTH_WORDS) : err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = in_req;
          err_d = acc_err;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = RESP;
            mem_en  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          mem_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mem_en) begin
      rd_ok_d   = !acc_err && !acc_req.we;
      rsp_err_d = acc_err;
    end else if ((state_q == RESP) && rsp_ready) begin
      rd_ok_d   = 1'b0;
      rsp_err_d = 1'b0;
    end

    // Reset on the commit edge must leave the array untouched.
    mem_we = mem_en && !rst && !acc_err && acc_req.we;
    mem_re = mem_en && !rst && !acc_err && !acc_req.we;

    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rd_ok_q ? arr_rdata : '0;
    rsp_err   = rsp_err_q;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .wr_en (mem_we),
    .rd_en (mem_re),
    .addr  (acc_req.addr[2 +: AW]),
    .wdata (acc_req.wdata),
    .be    (acc_req.be),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a byte-level memory model checked every cycle.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        sw_valid = 1'b0;
  logic [2:0]  sw_ready, sw_vld, sw_err;
  logic [31:0] sw_rdata [3];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(sw_valid), .req_ready(sw_ready[0]), .req_we(1'b1),
    .req_addr(32'h4), .req_wdata(32'h5A5A5A5A), .req_be(4'hF), .rsp_valid(sw_vld[0]),
    .rsp_ready(1'b1), .rsp_rdata(sw_rdata[0]), .rsp_err(sw_err[0]));
  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(sw_valid), .req_ready(sw_ready[1]), .req_we(1'b1),
    .req_addr(32'h4), .req_wdata(32'h5A5A5A5A), .req_be(4'hF), .rsp_valid(sw_vld[1]),
    .rsp_ready(1'b1), .rsp_rdata(sw_rdata[1]), .rsp_err(sw_err[1]));
  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(sw_valid), .req_ready(sw_ready[2]), .req_we(1'b1),
    .req_addr(32'h4), .req_wdata(32'h5A5A5A5A), .req_be(4'hF), .rsp_valid(sw_vld[2]),
    .rsp_ready(1'b1), .rsp_rdata(sw_rdata[2]), .rsp_err(sw_err[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory with per-byte "known" flags, one pending request.
  logic [7:0]  mb [DEPTH*4];
  bit          mk [DEPTH*4];
  bit          armed = 0, pend = 0, committed = 0, has_wr = 0, exp_err = 0;
  int          due = 0;
  logic [31:0] exp_rd, exp_msk, pw_addr, pw_data;
  logic [3:0]  pw_be;

  always @(negedge clk) begin
    bit was_pend;
    if (pend && !committed && cyc >= due) begin
      committed = 1;
      if (has_wr)
        for (int b = 0; b < 4; b++)
          if (pw_be[b]) begin
            mb[int'(pw_addr) + b] = pw_data[8*b +: 8];
            mk[int'(pw_addr) + b] = 1;
          end
    end
    if (rst) begin
      pend  = 0;
      armed = 1;
    end else if (armed) begin
      was_pend = pend;
      check("req_ready", {31'b0, req_ready}, {31'b0, !pend});
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, pend && cyc >= due});
      if (pend && cyc >= due) begin
        check("rsp_rdata", rsp_rdata & exp_msk, exp_rd & exp_msk);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
        if (rsp_ready) pend = 0;
      end
      if (!was_pend && req_valid) begin
        pend = 1; committed = 0; has_wr = 0;
        due = cyc + 1 + WC;
        exp_err = (req_addr % 4 != 0) || (req_addr >= 4 * DEPTH) || (req_we && req_be == 4'h0);
        exp_rd = '0; exp_msk = '1;
        if (!exp_err && req_we) begin
          has_wr = 1; pw_addr = req_addr; pw_data = req_wdata; pw_be = req_be;
        end else if (!exp_err) begin
          for (int b = 0; b < 4; b++) begin
            exp_rd[8*b +: 8]  = mb[int'(req_addr) + b];
            exp_msk[8*b +: 8] = mk[int'(req_addr) + b] ? 8'hFF : 8'h00;
          end
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er,
                        output int lat);
    int n;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    check("accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
    check("rsp_seen", {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, n;
    int          slat [3];

    for (int i = 0; i < DEPTH * 4; i++) mk[i] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_req_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;

    do_req(1, 32'h0, 32'hDEADBEEF, 4'hF, rd, er, lat);
    check("wr0_err", {31'b0, er}, 32'd0);
    check("wr0_rdata", rd, 32'h0);
    do_req(0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("rd0_data", rd, 32'hDEADBEEF);
    check("rd0_err", {31'b0, er}, 32'd0);
    check("rd0_latency", lat, 32'd3);

    do_req(1, 32'h10, 32'h11223344, 4'hF, rd, er, lat);
    do_req(1, 32'h10, 32'hAABBCCDD, 4'b0101, rd, er, lat);
    do_req(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("byte_lane_merge", rd, 32'h11BB33DD);

    do_req(0, 32'h3, 32'h0, 4'hF, rd, er, lat);
    check("misaligned_err", {31'b0, er}, 32'd1);
    check("misaligned_rdata", rd, 32'h0);
    do_req(0, 32'h400, 32'h0, 4'hF, rd, er, lat);
    check("range_err", {31'b0, er}, 32'd1);
    do_req(1, 32'h3FC, 32'hCAFEF00D, 4'hF, rd, er, lat);
    do_req(0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
    check("top_word_data", rd, 32'hCAFEF00D);
    check("top_word_err", {31'b0, er}, 32'd0);
    do_req(1, 32'h10, 32'hFFFFFFFF, 4'h0, rd, er, lat);
    check("be0_err", {31'b0, er}, 32'd1);
    do_req(0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("be0_no_effect", rd, 32'h11BB33DD);

    // Backpressured response with a second request waiting behind it.
    rsp_ready = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h10; req_be = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 50);
    @(posedge clk); #1 req_addr = 32'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_ready", {31'b0, req_ready}, 32'd0);
      check("stall_rdata", rsp_rdata, 32'h11BB33DD);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_release", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    check("second_rdata", rsp_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset while a write waits out its wait states.
    do_req(1, 32'h20, 32'h0, 4'hF, rd, er, lat);
    req_valid = 1; req_we = 1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    @(negedge clk);
    check("rst_wr_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_rst_rdata", rsp_rdata, 32'h0);
    check("post_rst_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    do_req(0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("rst_discard_write", rd, 32'h0);

    // Latency sweep over WAIT_CYCLES 0, 1, 3.
    for (int i = 0; i < 3; i++) slat[i] = 0;
    sw_valid = 1;
    @(negedge clk);
    check("sweep_ready", {29'b0, sw_ready}, 32'h7);
    @(posedge clk); #1 sw_valid = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (slat[i] == 0 && sw_vld[i]) begin
          slat[i] = c;
          check("sweep_err", {31'b0, sw_err[i]}, 32'd0);
          check("sweep_rdata", sw_rdata[i], 32'h0);
        end
    end
    check("latency_w0", slat[0], 32'd1);
    check("latency_w1", slat[1], 32'd2);
    check("latency_w3", slat[2], 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
